subpel_output_collector: RTL

//  Output-side counterpart to the row feeder of subpixel_interpolation. Captures the
//  8-pixel A/B/C half/quarter-pel FIR result rows (fir_out_a/b/c) into a ping-pong

---
 rtl/subpel_output_collector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/subpel_output_collector.sv
// ---------------------------------------------------------------------------
// subpel_output_collector
//
// Collects the per-row A/B/C half/quarter-pel FIR results of the subpixel
// interpolator into a two-bank ping-pong store. It then streams each
// completed frame (3 planes x NUM_ROWS rows) downstream as one row-sized word
// per handshake. One bank is filled from the capture side while the other
// drains.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   cap_valid     fir_a/b/c carry a valid result row
//   cap_ready     collector accepts a row this cycle (write bank is empty)
//   fir_a/b/c     plane A/B/C rows, pixel i at [i*PIXEL_W +: PIXEL_W]
//   out_valid     out_data/out_plane/out_row/out_last are valid
//   out_ready     downstream accepts the current word
//   out_data      streamed row
//   out_plane     0=A, 1=B, 2=C
//   out_row       row index within the plane
//   out_last      final word of a frame (plane C, last row)
//   frame_done    one-cycle pulse the cycle after the last word's handshake
// ---------------------------------------------------------------------------
module subpel_output_collector #(
  parameter int unsigned NUM_PIXEL = 8,
  parameter int unsigned PIXEL_W   = 8,
  parameter int unsigned NUM_ROWS  = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cap_valid,
  output logic                                cap_ready,
  input  logic [NUM_PIXEL*PIXEL_W-1:0]        fir_a,
  input  logic [NUM_PIXEL*PIXEL_W-1:0]        fir_b,
  input  logic [NUM_PIXEL*PIXEL_W-1:0]        fir_c,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_PIXEL*PIXEL_W-1:0]        out_data,
  output logic [1:0]                          out_plane,
  output logic [$clog2(NUM_ROWS)-1:0]         out_row,
  output logic                                out_last,
  output logic                                frame_done
);

  localparam int unsigned ROW_W = NUM_PIXEL * PIXEL_W;
  localparam int unsigned RW    = $clog2(NUM_ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
  localparam logic [1:0]    PLANE_C  = 2'd2;

  // Storage: [bank][plane][row]
  logic [ROW_W-1:0] mem [2][3][NUM_ROWS];

  logic [1:0]    bank_full;   // one FULL flag per bank
  logic          wb;          // bank being filled
  logic          rb;          // bank being drained
  logic [RW-1:0] wr_row;
  logic [RW-1:0] rd_row;
  logic [1:0]    rd_plane;

  logic cap_fire;
  logic out_fire;
  logic rd_at_last;

  always_comb begin
    cap_ready  = ~bank_full[wb];
    out_valid  = bank_full[rb];
    out_data   = mem[rb][rd_plane][rd_row];
    out_plane  = rd_plane;
    out_row    = rd_row;
    rd_at_last = (rd_plane == PLANE_C) && (rd_row == LAST_ROW);
    out_last   = out_valid & rd_at_last;
    cap_fire   = cap_valid & cap_ready;
    out_fire   = out_valid & out_ready;
  end

  // Row storage. Cleared on reset so out_data reads zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned p = 0; p < 3; p++)
          for (int unsigned r = 0; r < NUM_ROWS; r++)
            mem[b][p][r] <= '0;
    end else if (cap_fire) begin
      mem[wb][0][wr_row] <= fir_a;
      mem[wb][1][wr_row] <= fir_b;
      mem[wb][2][wr_row] <= fir_c;
    end
  end

  // Write side: fill bank wb row by row; hand it over once the last row lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb     <= 1'b0;
      wr_row <= '0;
    end else if (cap_fire) begin
      if (wr_row == LAST_ROW) begin
        wr_row <= '0;
        wb     <= ~wb;
      end else begin
        wr_row <= wr_row + 1'b1;
      end
    end
  end

  // Read side: plane-major walk A0..A7, B0..B7, C0..C7 over bank rb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb         <= 1'b0;
      rd_row     <= '0;
      rd_plane   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_fire & rd_at_last;
      if (out_fire) begin
        if (rd_at_last) begin
          rd_row   <= '0;
          rd_plane <= '0;
          rb       <= ~rb;
        end else if (rd_row == LAST_ROW) begin
          rd_row   <= '0;
          rd_plane <= rd_plane + 1'b1;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
      end
    end
  end

  // Bank flags. A fill completion only touches bank wb (which is empty) and a
  // drain completion only touches bank rb (which is full), so when both occur
  // in the same cycle they update different flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full <= '0;
    end else begin
      if (cap_fire && (wr_row == LAST_ROW))
        bank_full[wb] <= 1'b1;
      if (out_fire && rd_at_last)
        bank_full[rb] <= 1'b0;
    end
  end

endmodule
